// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter: store-and-forward RX buffer that commits only good, address-matched frames
// and replays them on an AXI-stream output with backpressure.
module eth_rx_frame_filter #(
  parameter int DEPTH = 2048,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic [47:0] local_mac,
  input  logic        promisc,
  output logic        drop_bad_frame,
  output logic        drop_overflow,
  output logic        drop_filtered
);
  localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [8:0]            ram [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, wr_commit, rd_ptr;
  logic [2:0]            cnt, cnt_nx;
  logic                  ovf, ucast_ok, bcast_ok, resync;
  logic                  beat, full, wr_en, in_hdr, load;
  logic                  ovf_nx, ucast_nx, bcast_nx, accept, runt, commit;
  logic [47:0]           mac_sh;

  assign beat     = s_axis_tvalid & ~resync;
  assign full     = (wr_ptr - rd_ptr) == FULL_LVL;
  assign wr_en    = beat & ~full;
  assign in_hdr   = cnt < 3'd6;
  assign mac_sh   = local_mac << (8 * cnt);
  assign cnt_nx   = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
  assign ovf_nx   = ovf | full;
  // Flags fold in the current beat so a 6-byte frame ending on byte 5 is judged correctly
  assign ucast_nx = ((cnt == 3'd0) | ucast_ok) & (~in_hdr | (s_axis_tdata == mac_sh[47:40]));
  assign bcast_nx = ((cnt == 3'd0) | bcast_ok) & (~in_hdr | (s_axis_tdata == 8'hFF));
  assign accept   = promisc | ucast_nx | bcast_nx;
  assign runt     = cnt_nx < 3'd6;
  assign commit   = ~s_axis_tuser & ~ovf_nx & ~runt & accept;
  assign load     = (~m_axis_tvalid | m_axis_tready) & (rd_ptr != wr_commit);

  always_ff @(posedge clk)
    if (wr_en) ram[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      wr_commit      <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      ucast_ok       <= 1'b0;
      bcast_ok       <= 1'b0;
      resync         <= 1'b1;
      drop_bad_frame <= 1'b0;
      drop_overflow  <= 1'b0;
      drop_filtered  <= 1'b0;
    end else begin
      drop_bad_frame <= 1'b0;
      drop_overflow  <= 1'b0;
      drop_filtered  <= 1'b0;
      if (s_axis_tvalid & s_axis_tlast) resync <= 1'b0;
      if (beat && s_axis_tlast) begin
        cnt            <= '0;
        ovf            <= 1'b0;
        ucast_ok       <= 1'b0;
        bcast_ok       <= 1'b0;
        wr_ptr         <= commit ? wr_ptr + 1'b1 : wr_commit;
        drop_bad_frame <= s_axis_tuser;
        drop_overflow  <= ~s_axis_tuser & ovf_nx;
        drop_filtered  <= ~s_axis_tuser & ~ovf_nx & (runt | ~accept);
        if (commit) wr_commit <= wr_ptr + 1'b1;
      end else if (beat) begin
        cnt      <= cnt_nx;
        ovf      <= ovf_nx;
        ucast_ok <= ucast_nx;
        bcast_ok <= bcast_nx;
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load) begin
      {m_axis_tlast, m_axis_tdata} <= ram[rd_ptr[ADDR_WIDTH-1:0]];
      m_axis_tvalid <= 1'b1;
      rd_ptr        <= rd_ptr + 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// tb_eth_rx_frame_filter: randomized frames against a frame-level accept/drop model and byte scoreboard.
module tb_eth_rx_frame_filter;
  localparam int DEPTH = 64;
  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  typedef logic [7:0] bq_t[$];

  logic clk = 0, rst_n = 0;
  logic [7:0] s_axis_tdata = 0, m_axis_tdata;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tuser = 0;
  logic m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;
  logic promisc = 0;
  logic drop_bad_frame, drop_overflow, drop_filtered;

  always #5 clk = ~clk;

  eth_rx_frame_filter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .local_mac(MAC), .promisc(promisc),
    .drop_bad_frame(drop_bad_frame), .drop_overflow(drop_overflow),
    .drop_filtered(drop_filtered)
  );

  int errors = 0, checks = 0;
  int n_bad = 0, n_ovf = 0, n_filt = 0, e_bad = 0, e_ovf = 0, e_filt = 0;
  int rx_bytes = 0, ready_mode = 0;
  logic [8:0] sb[$];
  logic [8:0] held;
  bit stalled = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output side: drive tready, count pulses, score handshakes, verify hold during stalls
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (drop_bad_frame) n_bad++;
      if (drop_overflow) n_ovf++;
      if (drop_filtered) n_filt++;
      if (stalled) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", {m_axis_tlast, m_axis_tdata}, held);
      end
      m_axis_tready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 3) != 0);
      if (m_axis_tvalid && m_axis_tready) begin
        rx_bytes++;
        check("out_expected", sb.size() > 0, 1);
        if (sb.size() > 0) check("out_byte", {m_axis_tlast, m_axis_tdata}, sb.pop_front());
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tlast, m_axis_tdata};
    end
  end

  function automatic bq_t mk_frame(input logic [47:0] dst, input int len);
    bq_t f;
    for (int i = 0; i < len; i++) f.push_back(i < 6 ? dst[47 - 8*i -: 8] : 8'($urandom));
    return f;
  endfunction

  task automatic beat(input logic [7:0] d, input logic last, input logic user);
    @(negedge clk);
    s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tlast = last; s_axis_tuser = user;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); s_axis_tvalid = 0; end
  endtask

  task automatic check_drops(input string tag);
    check({tag, "_bad"}, n_bad, e_bad);
    check({tag, "_ovf"}, n_ovf, e_ovf);
    check({tag, "_filt"}, n_filt, e_filt);
  endtask

  task automatic send_frame(input bq_t f, input logic user, input int gap, input bit exp_ovf, input bit lat);
    logic [47:0] d = 0;
    bit good = 0;
    int n = f.size();
    for (int i = 0; i < 6 && i < n; i++) d = {d[39:0], f[i]};
    if (user) e_bad++;
    else if (exp_ovf) e_ovf++;
    else if (n < 6 || !(promisc || d == MAC || d == BCAST)) e_filt++;
    else good = 1;
    for (int i = 0; i < n; i++) begin
      beat(f[i], i == n - 1, user && i == n - 1);
      if (i < n - 1) idle(gap == 2 ? $urandom_range(0, 2) : gap);
    end
    @(negedge clk);
    s_axis_tvalid = 0;
    if (good) for (int i = 0; i < n; i++) sb.push_back({i == n - 1, f[i]});
    if (lat) check("lat_n1_low", m_axis_tvalid, 0);
    @(negedge clk);
    if (lat) check("lat_n2_high", m_axis_tvalid, 1);
    check_drops("frame");
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && t < 3000) begin @(negedge clk); t++; end
    check("drain_left", sb.size(), 0);
    check("drain_timeout", t < 3000, 1);
  endtask

  task automatic sync_beat();
    beat(8'h00, 1, 0);
    idle(2);
    check_drops("sync");
  endtask

  initial begin
    bq_t f;
    int base, len, kind, t;
    repeat (3) @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_pulses", {drop_bad_frame, drop_overflow, drop_filtered}, 0);
    rst_n = 1;
    sync_beat();

    ready_mode = 1;
    send_frame(mk_frame(MAC, 64), 0, 0, 0, 1);
    drain();
    send_frame(mk_frame(MAC, 64), 1, 0, 0, 0);
    send_frame(mk_frame(BCAST, 50), 0, 0, 0, 0);
    drain();
    send_frame(mk_frame(OTHER, 30), 0, 0, 0, 0);
    send_frame(mk_frame(48'hFF_FF_FF_FF_FF_FE, 30), 0, 0, 0, 0);
    promisc = 1;
    send_frame(mk_frame(OTHER, 30), 0, 0, 0, 0);
    promisc = 0;
    send_frame(mk_frame(MAC, 4), 0, 0, 0, 0);
    send_frame(mk_frame(MAC, 6), 0, 0, 0, 0);
    drain();

    ready_mode = 0;
    repeat (2) @(negedge clk);
    base = rx_bytes;
    send_frame(mk_frame(MAC, 40), 0, 0, 0, 0);
    send_frame(mk_frame(MAC, 40), 0, 0, 1, 0);
    send_frame(mk_frame(MAC, 70), 0, 0, 1, 0);
    ready_mode = 1;
    drain();
    check("ovf_rx_count", rx_bytes - base, 40);
    send_frame(mk_frame(MAC, 30), 0, 0, 0, 0);
    send_frame(mk_frame(MAC, 70), 0, 0, 1, 0);
    send_frame(mk_frame(BCAST, 30), 0, 0, 0, 0);
    drain();

    f = mk_frame(MAC, 20);
    for (int i = 0; i < 5; i++) beat(f[i], 0, 0);
    @(negedge clk);
    rst_n = 0;
    s_axis_tvalid = 0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_pulses", {drop_bad_frame, drop_overflow, drop_filtered}, 0);
    @(negedge clk);
    rst_n = 1;
    base = rx_bytes;
    for (int i = 5; i < 20; i++) beat(f[i], i == 19, 0);
    idle(4);
    check_drops("resync");
    check("resync_no_out", rx_bytes - base, 0);
    check("resync_tvalid", m_axis_tvalid, 0);
    send_frame(mk_frame(MAC, 25), 0, 0, 0, 0);
    drain();

    ready_mode = 2;
    for (int k = 0; k < 100; k++) begin
      kind = $urandom_range(0, 5);
      len = kind == 3 ? $urandom_range(1, 5) : $urandom_range(6, 40);
      promisc = $urandom_range(0, 3) == 0;
      t = 0;
      while (sb.size() + len > DEPTH && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) check("space_wait", t, 0);
      send_frame(mk_frame(kind == 1 ? BCAST : kind == 2 ? OTHER :
                          kind == 5 ? {16'h0200, 32'($urandom)} : MAC, len),
                 kind == 4, 1, 0, 0);
    end
    ready_mode = 1;
    drain();
    check_drops("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/eth_rx_frame_filter.md
Name: eth_rx_frame_filter

Overview:
Store-and-forward receive buffer placed directly downstream of the GMII-to-AXI-stream frame receiver. It accepts the receiver's non-backpressurable byte stream, checks destination MAC, and buffers each frame. Only complete frames with good FCS and an accepted destination are committed; all others are rolled back. Committed frames are presented to the MAC/IP parser on an AXI-stream interface with tready.

Parameters:
DEPTH, 2048, buffer size in bytes; power of two, minimum 64.
ADDR_WIDTH, $clog2(DEPTH), buffer address width (derived; do not override).

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_axis_tdata  input  8  received byte
s_axis_tvalid  input  1  byte valid; no tready (source cannot stall); gaps allowed
s_axis_tlast  input  1  last byte of frame
s_axis_tuser  input  1  with tlast: 1 = bad frame/FCS
m_axis_tdata  output  8  buffered byte
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  last byte of committed frame
local_mac  input  48  station address; byte 0 on wire = local_mac[47:40]; stable during a frame
promisc  input  1  1 = accept any destination
drop_bad_frame  output  1  1-cycle pulse: frame dropped, tuser set
drop_overflow  output  1  1-cycle pulse: frame dropped, buffer full
drop_filtered  output  1  1-cycle pulse: frame dropped, MAC mismatch or runt

Behaviour:
- Reset (rst_n low, async): wr_ptr, wr_commit, rd_ptr = 0; m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0; all drop pulses 0; byte counter 0; per-frame flags cleared; resync = 1. Buffer RAM not reset.
- resync: after reset, input beats are discarded until a beat with tlast, which clears resync. No write, no drop pulse. This covers reset released mid-frame.
- Storage: RAM of DEPTH x 9 bits {tlast, tdata}. Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH. Address = low ADDR_WIDTH bits.
- full = (wr_ptr - rd_ptr) == DEPTH. This uses the uncommitted wr_ptr, so in-flight bytes count toward occupancy.
- Accepted beat (s_axis_tvalid=1, resync=0):
  - byte counter increments, saturating at 7.
  - full this cycle: set ovf flag; byte is not written. A read freeing space in the same cycle does not help.
  - otherwise: write at wr_ptr, wr_ptr++.
- MAC check for bytes 0..5: the byte is compared with the corresponding local_mac byte and with 0xFF. Per-frame flags are ucast_ok and bcast_ok. accept = promisc | ucast_ok | bcast_ok, evaluated after byte 5.
- On a tlast beat, exactly one outcome, in this priority:
  - tuser=1 -> rollback, pulse drop_bad_frame
  - ovf -> rollback, pulse drop_overflow
  - fewer than 6 bytes, or !accept -> rollback, pulse drop_filtered
  - else -> commit: wr_commit <= wr_ptr+1 (includes this beat)
- Rollback: wr_ptr <= wr_commit.
- After the tlast beat, byte counter and flags clear for the next frame.
- Pulses are registered and asserted in the cycle after the tlast beat.
- Read side:
  - Output stage is a single register loaded by synchronous RAM read.
  - Load when (!m_axis_tvalid | m_axis_tready) & (rd_ptr != wr_commit); rd_ptr++.
  - Otherwise, m_axis_tready clears m_axis_tvalid.
  - m_axis_tdata and m_axis_tlast are held while tvalid=1 and tready=0.
- Latency: with an empty buffer, if the tlast beat is in cycle N, m_axis_tvalid rises in cycle N+2. Sustained throughput is 1 byte/cycle with tready=1.
- Uncommitted bytes are never visible on the output.
- Commit and read in the same cycle are independent and both take effect.
- A frame longer than DEPTH is always dropped with drop_overflow. The buffer is still consistent afterwards.

Test Plan:
- 64-byte frame, dst = local_mac 02:00:00:00:00:01, tuser=0, tready=1 -> identical 64 bytes out, tlast on byte 63, tvalid rises 2 cycles after input tlast, no drop pulse.
- Same frame with tuser=1 on tlast, followed by a good broadcast frame (FF:FF:FF:FF:FF:FF) -> drop_bad_frame pulse once; only the broadcast frame appears on output.
- dst 02:00:00:00:00:02 with promisc=0 -> drop_filtered, no output. Repeat with promisc=1 -> frame output intact. A 4-byte frame -> drop_filtered.
- DEPTH=64, tready=0, send a 40-byte good frame then a 40-byte good frame -> first committed; second gets drop_overflow. Then tready=1 -> exactly 40 bytes out, and a subsequent 30-byte frame passes.
- Input valid every other cycle (MII rate) with random tready stalls over 100 frames -> scoreboard match, output data held stable during stalls.
- Assert rst_n low mid-frame, release while the frame continues -> remainder discarded without pulse, no output; the next full frame passes normally.
